// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared scoreboard entry type, forwarding constant and select-width helper
package hazard_pkg;

   // Entry register field is sized for the widest supported register address.
   localparam int RW_MAX = 8;
   localparam int FWD_RF = 0;

   typedef struct packed {
      logic              valid;
      logic [RW_MAX-1:0] rw;
      logic              regWrite;
      logic              memRead;
   } sb_entry_t;

   function automatic int calc_sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and stall/forward response bundle
interface hazard_scoreboard_if
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int RD_PORTS       = 2,
   parameter int PIPE_DEPTH     = 3,
   parameter int CNT_WIDTH      = 16
);
   localparam int SEL_W = calc_sel_w(PIPE_DEPTH);

   logic                               id_valid;
   logic [RD_PORTS*REG_ADDR_WIDTH-1:0] id_rr;
   logic [RD_PORTS-1:0]                id_rr_used;
   logic [REG_ADDR_WIDTH-1:0]          id_rw;
   logic                               id_regWrite;
   logic                               id_memRead;
   logic                               ex_flush;
   logic                               stall;
   logic [RD_PORTS*SEL_W-1:0]          fwd_sel;
   logic [CNT_WIDTH-1:0]               stall_count;

   modport master (
      output id_valid, id_rr, id_rr_used, id_rw, id_regWrite, id_memRead, ex_flush,
      input  stall, fwd_sel, stall_count
   );

   modport slave (
      input  id_valid, id_rr, id_rr_used, id_rw, id_regWrite, id_memRead, ex_flush,
      output stall, fwd_sel, stall_count
   );

endinterface

// File: rtl/hazard_port_match.sv
// rtl/hazard_port_match.sv - per read port youngest match, ready flag and stall
// HAZARD_FWD_EN selects forwarding; otherwise any match stalls and fwd_sel stays at the regfile.
module hazard_port_match
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int PIPE_DEPTH     = 3,
   parameter int ALU_READY      = 2,
   parameter int LOAD_READY     = 3,
   parameter int SEL_W          = 2
) (
   input  logic                          req_i,
   input  logic [REG_ADDR_WIDTH-1:0]     rr_i,
   input  sb_entry_t [PIPE_DEPTH-1:0]    entries_i,
   output logic                          stall_o,
   output logic [SEL_W-1:0]              fwd_sel_o
);

`ifdef HAZARD_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic             match;
   logic             match_ld;
   logic [SEL_W-1:0] match_stage;
   logic             ready;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      match       = 1'b0;
      match_ld    = 1'b0;
      match_stage = '0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         if (req_i && (rr_i != '0) && entries_i[k].valid && entries_i[k].regWrite &&
             (entries_i[k].rw == RW_MAX'(rr_i))) begin
            match       = 1'b1;
            match_ld    = entries_i[k].memRead;
            match_stage = SEL_W'(k + 1);
         end
      end
   end

   always_comb begin
      ready = match_ld ? (int'(match_stage) >= LOAD_READY) : (int'(match_stage) >= ALU_READY);
   end

   always_comb begin
      stall_o   = match && !(FWD_ON && ready);
      fwd_sel_o = (FWD_ON && match && ready) ? match_stage : SEL_W'(FWD_RF);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write tracker issuing ID stall and forwarding selects
// Forwarding behaviour is selected in hazard_port_match by HAZARD_FWD_EN.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int RD_PORTS       = 2,
   parameter int PIPE_DEPTH     = 3,
   parameter int ALU_READY      = 2,
   parameter int LOAD_READY     = 3,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  sb
);

   localparam int SEL_W = calc_sel_w(PIPE_DEPTH);

   sb_entry_t [PIPE_DEPTH-1:0]  pipe_q;
   sb_entry_t [PIPE_DEPTH-1:0]  pipe_d;
   logic [CNT_WIDTH-1:0]        cnt_q;
   logic [CNT_WIDTH-1:0]        cnt_d;
   logic [RD_PORTS-1:0]         port_stall;
   logic [RD_PORTS*SEL_W-1:0]   fwd_sel;
   logic                        stall;

   for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
      hazard_port_match #(
         .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
         .PIPE_DEPTH     (PIPE_DEPTH),
         .ALU_READY      (ALU_READY),
         .LOAD_READY     (LOAD_READY),
         .SEL_W          (SEL_W)
      ) u_match (
         .req_i     (sb.id_valid && sb.id_rr_used[p]),
         .rr_i      (sb.id_rr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
         .entries_i (pipe_q),
         .stall_o   (port_stall[p]),
         .fwd_sel_o (fwd_sel[p*SEL_W +: SEL_W])
      );
   end

   assign stall = |port_stall;

   // A stall inserts a bubble into EX; a flush kills the old EX entry as it moves on.
   always_comb begin
      pipe_d = '0;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         pipe_d[k] = pipe_q[k-1];
         if (k == 1 && sb.ex_flush) begin
            pipe_d[k].valid = 1'b0;
         end
      end
      if (sb.id_valid && !stall) begin
         pipe_d[0].valid    = 1'b1;
         pipe_d[0].rw       = RW_MAX'(sb.id_rw);
         pipe_d[0].regWrite = sb.id_regWrite;
         pipe_d[0].memRead  = sb.id_memRead;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q <= '0;
         cnt_q  <= '0;
      end else begin
         pipe_q <= pipe_d;
         cnt_q  <= cnt_d;
      end
   end

   assign sb.stall       = stall;
   assign sb.fwd_sel     = fwd_sel;
   assign sb.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and random checks of hazard_scoreboard against an in-flight list model
module tb_hazard_scoreboard;

   localparam int CW    = 10;
   localparam int DEPTH = 3;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(
      .REG_ADDR_WIDTH (5), .RD_PORTS (2), .PIPE_DEPTH (DEPTH), .CNT_WIDTH (CW)
   ) sb ();

   hazard_scoreboard #(
      .REG_ADDR_WIDTH (5), .RD_PORTS (2), .PIPE_DEPTH (DEPTH),
      .ALU_READY (2), .LOAD_READY (3), .CNT_WIDTH (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb)
   );

   // Model: list of in-flight register writers, each tagged with its age (= stage number).
   typedef struct { int age; int rw; bit ld; } rec_t;
   rec_t fl[$];
   int   m_cnt;

   int         checks = 0;
   int         errors = 0;
   bit         obs_stall;
   logic [3:0] obs_fwd;
   int         obs_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_out(input bit v, input int r0, input int r1, input bit [1:0] used,
                                     output bit st, output logic [3:0] fs);
      int rr[2];
      int best;
      bit bld;
      rr[0] = r0;
      rr[1] = r1;
      st = 1'b0;
      fs = '0;
      for (int p = 0; p < 2; p++) begin
         best = 0;
         bld  = 1'b0;
         if (v && used[p] && rr[p] != 0) begin
            foreach (fl[i]) begin
               if (fl[i].rw == rr[p] && (best == 0 || fl[i].age < best)) begin
                  best = fl[i].age;
                  bld  = fl[i].ld;
               end
            end
         end
         if (best != 0) begin
            if (FWD && (bld ? best >= 3 : best >= 2)) fs[p*2 +: 2] = 2'(best);
            else st = 1'b1;
         end
      end
   endfunction

   function automatic void model_step(input bit r, input bit v, input int rw, input bit wr,
                                      input bit ld, input bit f, input bit st);
      rec_t nq[$];
      if (r) begin
         fl.delete();
         m_cnt = 0;
         return;
      end
      if (st && m_cnt < CMAX) m_cnt++;
      foreach (fl[i]) begin
         if (!(f && fl[i].age == 1) && fl[i].age < DEPTH) nq.push_back('{fl[i].age + 1, fl[i].rw, fl[i].ld});
      end
      if (v && !st && wr) nq.push_back('{1, rw, ld});
      fl = nq;
   endfunction

   // Called at negedge: drive, check against model before the edge, then advance model.
   task automatic run_cycle(input bit r, input bit v, input int r0, input int r1, input bit [1:0] used,
                            input int rw, input bit wr, input bit ld, input bit f);
      bit         est;
      logic [3:0] efs;
      rst            = r;
      sb.id_valid    = v;
      sb.id_rr       = {5'(r1), 5'(r0)};
      sb.id_rr_used  = used;
      sb.id_rw       = 5'(rw);
      sb.id_regWrite = wr;
      sb.id_memRead  = ld;
      sb.ex_flush    = f;
      #1;
      model_out(v, r0, r1, used, est, efs);
      obs_stall = sb.stall;
      obs_fwd   = sb.fwd_sel;
      obs_cnt   = int'(sb.stall_count);
      chk("stall", 32'(sb.stall), 32'(est));
      chk("fwd_sel", 32'(sb.fwd_sel), 32'(efs));
      chk("stall_count", 32'(sb.stall_count), 32'(m_cnt));
      @(posedge clk);
      model_step(r, v, rw, wr, ld, f, est);
      @(negedge clk);
   endtask

   // Hold one instruction in ID until it issues; reports the number of stalled cycles.
   task automatic issue(input int r0, input int r1, input bit [1:0] used, input int rw,
                        input bit wr, input bit ld, output int nst);
      nst = 0;
      for (int n = 0; n < 8; n++) begin
         run_cycle(1'b0, 1'b1, r0, r1, used, rw, wr, ld, 1'b0);
         if (!obs_stall) return;
         nst++;
      end
      chk("issue_bound", 32'(obs_stall), 32'd0);
   endtask

   task automatic do_reset();
      run_cycle(1'b1, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int n;
      int tot;
      rst            = 1'b1;
      sb.id_valid    = 1'b0;
      sb.id_rr       = '0;
      sb.id_rr_used  = '0;
      sb.id_rw       = '0;
      sb.id_regWrite = 1'b0;
      sb.id_memRead  = 1'b0;
      sb.ex_flush    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      fl.delete();
      m_cnt = 0;

      run_cycle(1'b0, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
      chk("reset_stall", 32'(obs_stall), 32'd0);
      chk("reset_cnt", 32'(obs_cnt), 32'd0);

      // addu $3 then addu $4,$3
      do_reset();
      issue(0, 0, 2'b00, 3, 1'b1, 1'b0, n);
      issue(3, 0, 2'b01, 4, 1'b1, 1'b0, n);
      chk("t1_stalls", 32'(n), FWD ? 32'd1 : 32'd3);
      chk("t1_fwd0", 32'(obs_fwd[1:0]), FWD ? 32'd2 : 32'd0);

      // lw $5 then addu $6,$5
      do_reset();
      issue(0, 0, 2'b00, 5, 1'b1, 1'b1, n);
      issue(5, 0, 2'b01, 6, 1'b1, 1'b0, n);
      chk("t2_stalls", 32'(n), FWD ? 32'd2 : 32'd3);
      chk("t2_fwd0", 32'(obs_fwd[1:0]), FWD ? 32'd3 : 32'd0);
      chk("t2_cnt", 32'(obs_cnt), FWD ? 32'd2 : 32'd3);

      // writes to $0 never hazard
      do_reset();
      issue(0, 0, 2'b00, 0, 1'b1, 1'b0, n);
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b0, 1'b1, 0, 0, 2'b11, 0, 1'b1, 1'b0, 1'b0);
         chk("t3_stall", 32'(obs_stall), 32'd0);
         chk("t3_fwd", 32'(obs_fwd), 32'd0);
      end

      // flushed writer in EX leaves no hazard
      do_reset();
      issue(0, 0, 2'b00, 7, 1'b1, 1'b0, n);
      run_cycle(1'b0, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b1);
      run_cycle(1'b0, 1'b1, 7, 7, 2'b11, 9, 1'b1, 1'b0, 1'b0);
      chk("t4_stall", 32'(obs_stall), 32'd0);
      chk("t4_fwd", 32'(obs_fwd), 32'd0);

      // youngest writer wins
      do_reset();
      issue(0, 0, 2'b00, 8, 1'b1, 1'b0, n);
      issue(0, 0, 2'b00, 8, 1'b1, 1'b0, n);
      issue(0, 8, 2'b10, 12, 1'b1, 1'b0, n);
      chk("t5_stalls", 32'(n), FWD ? 32'd1 : 32'd3);
      chk("t5_fwd1", 32'(obs_fwd[3:2]), FWD ? 32'd2 : 32'd0);

      // counter saturation
      do_reset();
      tot = 0;
      for (int it = 0; it < 3000 && tot < CMAX + 4; it++) begin
         issue(1, 0, 2'b01, 1, 1'b1, 1'b0, n);
         tot += n;
      end
      run_cycle(1'b0, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
      chk("sat_reached", 32'(tot >= CMAX + 4), 32'd1);
      chk("sat_cnt", 32'(obs_cnt), 32'(CMAX));

      // fill all stages, reset mid-stream
      issue(0, 0, 2'b00, 9, 1'b1, 1'b0, n);
      issue(0, 0, 2'b00, 10, 1'b1, 1'b0, n);
      issue(0, 0, 2'b00, 11, 1'b1, 1'b0, n);
      run_cycle(1'b1, 1'b1, 11, 9, 2'b11, 12, 1'b1, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b1, 9, 10, 2'b11, 13, 1'b1, 1'b0, 1'b0);
      chk("t6_stall", 32'(obs_stall), 32'd0);
      chk("t6_fwd", 32'(obs_fwd), 32'd0);
      chk("t6_cnt", 32'(obs_cnt), 32'd0);

      // random traffic over a small register set to provoke hazards
      for (int i = 0; i < 600; i++) begin
         run_cycle($urandom_range(0, 49) == 0,
                   $urandom_range(0, 9) < 8,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) < 3,
                   $urandom_range(0, 9) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
